alu_seq_nbit: RTL and testbench
===============================

Name: alu_seq_nbit

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- WIDTH-bit operands; valid/ready handshake on the input and the output.
- Adds signed flags (NEG, OVF), arithmetic shift, and an iterative shift-add unsigned multiply that takes several cycles.
- Sits between the operand/decode stage and the writeback stage. Only one operation is in flight at a time.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter; derived, do not override.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept a request this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- SEL  in  4  opcode.
- OUT_VALID  out  1  result and flags are valid.
- OUT_READY  in  1  downstream accepts the result.
- RESULT  out  WIDTH  result; low half of the product for MUL.
- RESULT_HI  out  WIDTH  high half of the product for MUL; 0 for every other op.
- CARRY  out  1  carry / borrow / shifted-out bit.
- ZERO  out  1  result is all zeros.
- NEG  out  1  MSB of RESULT.
- OVF  out  1  signed overflow.
- BUSY  out  1  a multiply is in progress.

Behaviour:
- Reset: all outputs go to 0, FSM goes to IDLE, operand and accumulator registers are cleared. Reset asserted mid-MUL aborts the multiply and drops the result.
- FSM states: IDLE, MUL, HOLD.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). A request is accepted only when IN_VALID && IN_READY. IN_VALID with IN_READY low is ignored; A, B and SEL are not sampled.
- Single-cycle ops accepted in IDLE: result and flags are registered at that edge, OUT_VALID=1 on the next cycle, state stays IDLE. Latency is 1 cycle.
- Back-to-back issue: OUT_VALID && OUT_READY && new accept in the same cycle replaces the result with no bubble.
- Output stall: OUT_VALID && !OUT_READY holds RESULT, RESULT_HI and all flags stable. IN_READY is low during the stall.
- OUT_VALID clears on OUT_VALID && OUT_READY with no new accept.
- Opcodes (RESULT / CARRY):
  - 0 ADD: A+B / carry out. OVF = signed overflow.
  - 1 SUB: A-B / 1 when A<B unsigned (borrow). OVF = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: CARRY=0, OVF=0.
  - 6 SHL by 1: CARRY = A[WIDTH-1].
  - 7 SHR by 1, logical: CARRY = A[0].
  - 8 MUL: unsigned A*B (see below).
  - 9 ASR by 1, sign-preserving: CARRY = A[0].
  - 10-15 reserved: RESULT = A, CARRY=0, OVF=0.
- Flags: ZERO = (RESULT==0), except for MUL where ZERO = (full product==0). NEG = RESULT[WIDTH-1] for all ops except MUL, where NEG=0.
- MUL sequence:
  - On accept: latch A and B, clear the accumulator, move to MUL, BUSY=1, counter=0.
  - Each MUL cycle: if multiplier LSB is 1, add the multiplicand into the upper accumulator half; then shift the accumulator right by 1; counter+1.
  - After WIDTH iterations: move to HOLD, BUSY=0, OUT_VALID=1 with {RESULT_HI,RESULT} = product.
  - Flags: CARRY = |RESULT_HI, NEG=0, OVF=0.
  - Latency from accept to OUT_VALID is exactly WIDTH+1 cycles.
  - IN_READY=0 throughout MUL and HOLD.
  - HOLD goes to IDLE on OUT_READY.
- Widths: the adder is WIDTH+1 bits; the accumulator is 2*WIDTH+1 bits; the product never truncates.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_ASR (4-bit);
  - FSM state encodings S_IDLE, S_MUL, S_HOLD.
- Sub-module alu_comb_nbit (parameter WIDTH): purely combinational single-cycle ops and flags.
- alu_seq_nbit contains the handshake logic, the FSM, the multiply datapath and the output registers.

Test Plan:
- Reset and ADD, WIDTH=8:
  - RST mid-idle, then release -> all outputs 0.
  - A=0x7F, B=0x01, SEL=0 -> next cycle RESULT=0x80, OVF=1, NEG=1, CARRY=0, ZERO=0.
- SUB with borrow: A=0x03, B=0x05, SEL=1 -> RESULT=0xFE, CARRY=1, NEG=1, OVF=0. Then A=B=0x5A -> RESULT=0, ZERO=1.
- Shifts:
  - A=0x81, SEL=6 -> RESULT=0x02, CARRY=1.
  - A=0x81, SEL=7 -> RESULT=0x40, CARRY=1.
  - A=0x81, SEL=9 -> RESULT=0xC0, CARRY=1.
- MUL:
  - A=0xFF, B=0xFF, SEL=8 -> BUSY=1 for 8 cycles, IN_READY=0, OUT_VALID exactly 9 cycles after accept; RESULT_HI=0xFE, RESULT=0x01, CARRY=1.
  - A=0, B=0x37 -> product 0, ZERO=1.
- Backpressure:
  - Hold OUT_READY=0 for 5 cycles after an ADD -> outputs stable, IN_READY=0, new IN_VALID ignored.
  - Raise OUT_READY together with a new XOR request -> XOR result appears the next cycle with no bubble.
- Reset mid-MUL: assert RST 3 cycles into a MUL -> outputs 0 immediately, no OUT_VALID after release; the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encodings for alu_seq_nbit
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_nbit.sv
// rtl/alu_comb_nbit.sv - combinational single-cycle ALU operations and flags
//
// Ports:
//   i_a, i_b   operands (WIDTH bits)
//   i_sel      4-bit opcode
//   o_result   operation result (A for MUL and reserved opcodes)
//   o_carry    carry / borrow / shifted-out bit
//   o_zero     result is all zeros
//   o_neg      MSB of the result
//   o_ovf      signed overflow (ADD/SUB only)
module alu_comb_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_sel,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit so the carry and the borrow fall out of the top bit.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        case (i_sel)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
                // Overflow: same-sign operands giving a differently-signed sum.
                o_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_carry  = w_diff[WIDTH];
                // Overflow: opposite-sign operands and the sign of A is lost.
                o_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_carry  = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            OP_ASR: begin
                o_result = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            default: ;
        endcase
        o_zero = (o_result == '0);
        o_neg  = o_result[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// rtl/alu_seq_nbit.sv - registered ALU with valid/ready handshake and iterative multiply
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_in_valid         operation request
//   o_in_ready         request can be accepted this cycle
//   i_a, i_b, i_sel    operands and opcode
//   o_out_valid        result and flags valid
//   i_out_ready        downstream accepts the result
//   o_result           result (low product half for MUL)
//   o_result_hi        high product half for MUL, 0 otherwise
//   o_carry, o_zero, o_neg, o_ovf   flags
//   o_busy             multiply in progress
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_sel,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
    output logic             o_busy
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_product;

    logic [WIDTH-1:0]   w_c_result;
    logic               w_c_carry;
    logic               w_c_zero;
    logic               w_c_neg;
    logic               w_c_ovf;

    alu_comb_nbit #(.WIDTH(WIDTH)) u_comb (
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sel    (i_sel),
        .o_result (w_c_result),
        .o_carry  (w_c_carry),
        .o_zero   (w_c_zero),
        .o_neg    (w_c_neg),
        .o_ovf    (w_c_ovf)
    );

    assign w_in_ready = (r_state == S_IDLE) && (!o_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && w_in_ready;
    assign o_in_ready = w_in_ready;

    // Shift-add step: conditionally add the multiplicand into the upper half
    // (the top accumulator bit keeps the carry), then shift right by one.
    // After WIDTH steps the low 2*WIDTH bits hold the full product.
    assign w_upper    = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {1'b0, w_upper, r_acc[WIDTH-1:1]};
    assign w_product  = w_acc_next[2*WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            o_out_valid <= 1'b0;
            o_result    <= '0;
            o_result_hi <= '0;
            o_carry     <= 1'b0;
            o_zero      <= 1'b0;
            o_neg       <= 1'b0;
            o_ovf       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_sel == OP_MUL) begin
                            r_mcand     <= i_a;
                            r_mplier    <= i_b;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            o_busy      <= 1'b1;
                            o_out_valid <= 1'b0;
                            r_state     <= S_MUL;
                        end else begin
                            o_result    <= w_c_result;
                            o_result_hi <= '0;
                            o_carry     <= w_c_carry;
                            o_zero      <= w_c_zero;
                            o_neg       <= w_c_neg;
                            o_ovf       <= w_c_ovf;
                            o_out_valid <= 1'b1;
                        end
                    end else if (o_out_valid && i_out_ready) begin
                        o_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        o_result    <= w_product[WIDTH-1:0];
                        o_result_hi <= w_product[2*WIDTH-1:WIDTH];
                        o_carry     <= |w_product[2*WIDTH-1:WIDTH];
                        o_zero      <= (w_product == '0);
                        o_neg       <= 1'b0;
                        o_ovf       <= 1'b0;
                        o_busy      <= 1'b0;
                        o_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// tb/tb_alu_seq_nbit.sv - directed self-checking bench for alu_seq_nbit
module tb_alu_seq_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int seen_valid;

    alu_seq_nbit #(.WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_sel       (sel),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_result_hi (result_hi),
        .o_carry     (carry),
        .o_zero      (zero),
        .o_neg       (neg),
        .o_ovf       (ovf),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] s, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        sel      = s;
        a        = va;
        b        = vb;
    endtask

    // Checks result, hi, carry, zero, neg, ovf in one go.
    task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] h,
                           input logic c, input logic z, input logic n, input logic o);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".result"}, result, r);
        chk({tag, ".hi"}, result_hi, h);
        chk({tag, ".carry"}, carry, c);
        chk({tag, ".zero"}, zero, z);
        chk({tag, ".neg"}, neg, n);
        chk({tag, ".ovf"}, ovf, o);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sel       = '0;
        tick();
        tick();
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.result", result, 8'h00);
        chk("rst.busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // ADD with signed overflow
        issue(4'd0, 8'h7F, 8'h01);
        chk("add.in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_out("add_ovf", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset while idle with a valid result
        rst = 1'b1;
        #1;
        chk("rst_idle.valid", out_valid, 1'b0);
        chk("rst_idle.result", result, 8'h00);
        chk("rst_idle.neg", neg, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back single-cycle ops
        issue(4'd1, 8'h03, 8'h05);
        tick();
        chk_out("sub_borrow", 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(4'd1, 8'h5A, 8'h5A);
        tick();
        chk_out("sub_zero", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'd0, 8'hFF, 8'h01);
        tick();
        chk_out("add_carry", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(4'd6, 8'h81, 8'h00);
        tick();
        chk_out("shl", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd7, 8'h81, 8'h00);
        tick();
        chk_out("shr", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 8'h81, 8'h00);
        tick();
        chk_out("asr", 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(4'd5, 8'h0F, 8'h00);
        tick();
        chk_out("not", 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'd12, 8'h3C, 8'hFF);
        tick();
        chk_out("reserved", 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("drain.valid", out_valid, 1'b0);

        // MUL 0xFF * 0xFF: busy for 8 cycles, valid on the 9th
        issue(4'd8, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("mul_ff.busy%0d", i), busy, 1'b1);
            chk($sformatf("mul_ff.nvalid%0d", i), out_valid, 1'b0);
            chk($sformatf("mul_ff.in_ready%0d", i), in_ready, 1'b0);
            tick();
        end
        chk("mul_ff.busy_done", busy, 1'b0);
        chk_out("mul_ff", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mul_ff.hold_in_ready", in_ready, 1'b0);
        tick();
        chk("mul_ff.released", out_valid, 1'b0);
        chk("mul_ff.idle_in_ready", in_ready, 1'b1);

        // MUL with zero operand
        issue(4'd8, 8'h00, 8'h37);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk_out("mul_zero", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // MUL with zero low half but nonzero product
        issue(4'd8, 8'h10, 8'h10);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk_out("mul_100", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Backpressure: stall 5 cycles with a pending request ignored
        out_ready = 1'b0;
        issue(4'd0, 8'h10, 8'h20);
        tick();
        issue(4'd4, 8'hF0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall.result%0d", i), result, 8'h30);
            chk($sformatf("stall.valid%0d", i), out_valid, 1'b1);
            chk($sformatf("stall.in_ready%0d", i), in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_out("xor_no_bubble", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("xor.drain", out_valid, 1'b0);

        // Reset three cycles into a MUL
        issue(4'd8, 8'h03, 8'h05);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mul.busy", busy, 1'b0);
        chk("rst_mul.valid", out_valid, 1'b0);
        chk("rst_mul.result", result, 8'h00);
        tick();
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        chk("rst_mul.no_valid", seen_valid, 0);
        issue(4'd0, 8'h02, 8'h03);
        tick();
        in_valid = 1'b0;
        chk_out("add_after_rst", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
